// File: rtl/if_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_if : fetch-stage hazard, redirect, memory and IF/ID signals |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface if_fetch_if;
   logic [1:0]  HzCtrl;
   logic [1:0]  PCSrc;
   logic [31:0] BranchTarget;
   logic [31:0] JumpTarget;
   logic [31:0] JrTarget;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemRData;
   logic [31:0] Inst;
   logic [31:0] PC4;
   logic        InstValid;

   // The fetch stage masters the instruction-memory transaction.
   modport master (
      input  HzCtrl, PCSrc, BranchTarget, JumpTarget, JrTarget, IMemAck, IMemRData,
      output IMemReq, IMemAddr, Inst, PC4, InstValid
   );

   modport slave (
      output HzCtrl, PCSrc, BranchTarget, JumpTarget, JrTarget, IMemAck, IMemRData,
      input  IMemReq, IMemAddr, Inst, PC4, InstValid
   );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch : MIPS32 instruction fetch stage with PC and redirect logic |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   if_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic        kill_q, kill_d;
   logic [31:0] kill_pc_q, kill_pc_d;

   logic        w_redirect;
   logic [31:0] w_target;

   assign w_redirect = (bus.PCSrc != 2'b00);

   always_comb begin
      w_target = 32'h0000_0000;
      case (bus.PCSrc)
         2'b01:   w_target = {bus.BranchTarget[31:2], 2'b00};
         2'b10:   w_target = {bus.JumpTarget[31:2], 2'b00};
         2'b11:   w_target = {bus.JrTarget[31:2], 2'b00};
         default: w_target = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         inst_buf_q <= 32'h0000_0000;
         kill_q     <= 1'b0;
         kill_pc_q  <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_buf_q <= inst_buf_d;
         kill_q     <= kill_d;
         kill_pc_q  <= kill_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_buf_d = inst_buf_q;
      kill_d     = kill_q;
      kill_pc_d  = kill_pc_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            // An in-flight request always completes; stale data is dropped on ack.
            if (bus.IMemAck) begin
               if (w_redirect) begin
                  pc_d   = w_target;
                  kill_d = 1'b0;
               end else if (kill_q) begin
                  pc_d   = kill_pc_q;
                  kill_d = 1'b0;
               end else begin
                  inst_buf_d = bus.IMemRData;
                  state_d    = S_HOLD;
               end
            end else if (w_redirect) begin
               kill_d    = 1'b1;
               kill_pc_d = w_target;
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               pc_d       = w_target;
               inst_buf_d = 32'h0000_0000;
               state_d    = S_REQ;
            end else if (!bus.HzCtrl[1]) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.IMemReq   = (state_q == S_REQ);
   assign bus.IMemAddr  = pc_q;
   assign bus.InstValid = (state_q == S_HOLD);
   assign bus.Inst      = (state_q == S_HOLD) ? inst_buf_q : 32'h0000_0000;
   assign bus.PC4       = pc_q + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_fetch : cycle-table and reset-sequence bench for if_fetch      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_if_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          N_VEC    = 23;

   typedef struct {
      logic [1:0]  hz;
      logic [1:0]  src;
      logic        ack;
      logic [31:0] rdata;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc4;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   vec_t vecs [N_VEC];
   vec_t exp_q [$];

   if_fetch_if bus ();

   if_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic [1:0] hz, input logic [1:0] src, input logic ack,
                               input logic [31:0] rdata, input logic [31:0] tgt,
                               input logic req, input logic [31:0] addr, input logic valid,
                               input logic [31:0] inst, input logic [31:0] pc4);
      vec_t v;
      v.hz = hz; v.src = src; v.ack = ack; v.rdata = rdata; v.tgt = tgt;
      v.req = req; v.addr = addr; v.valid = valid; v.inst = inst; v.pc4 = pc4;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input vec_t v);
      bus.HzCtrl       = v.hz;
      bus.PCSrc        = v.src;
      bus.IMemAck      = v.ack;
      bus.IMemRData    = v.rdata;
      // Unselected targets carry junk so a wrong select shows up.
      bus.BranchTarget = (v.src == 2'b01) ? v.tgt : 32'hBAD0_0101;
      bus.JumpTarget   = (v.src == 2'b10) ? v.tgt : 32'hBAD0_0202;
      bus.JrTarget     = (v.src == 2'b11) ? v.tgt : 32'hBAD0_0303;
   endtask

   initial begin
      vec_t e;
      //           hz src ack rdata          tgt            req addr           vld inst           pc4
      vecs[0]  = mk(0, 0, 0, 32'h0,          32'h0,          0, 32'h0,          0, 32'h0,          32'h4);
      vecs[1]  = mk(0, 0, 1, 32'h2008_0005,  32'h0,          1, 32'h0,          0, 32'h0,          32'h4);
      vecs[2]  = mk(0, 0, 0, 32'h0,          32'h0,          0, 32'h0,          1, 32'h2008_0005,  32'h4);
      vecs[3]  = mk(0, 0, 0, 32'h0,          32'h0,          1, 32'h4,          0, 32'h0,          32'h8);
      vecs[4]  = mk(1, 0, 0, 32'h0,          32'h0,          1, 32'h4,          0, 32'h0,          32'h8);
      vecs[5]  = mk(2, 0, 0, 32'h0,          32'h0,          1, 32'h4,          0, 32'h0,          32'h8);
      vecs[6]  = mk(0, 0, 1, 32'h8C09_0000,  32'h0,          1, 32'h4,          0, 32'h0,          32'h8);
      vecs[7]  = mk(2, 0, 0, 32'h0,          32'h0,          0, 32'h4,          1, 32'h8C09_0000,  32'h8);
      vecs[8]  = mk(2, 0, 0, 32'h0,          32'h0,          0, 32'h4,          1, 32'h8C09_0000,  32'h8);
      vecs[9]  = mk(2, 0, 0, 32'h0,          32'h0,          0, 32'h4,          1, 32'h8C09_0000,  32'h8);
      vecs[10] = mk(3, 0, 0, 32'h0,          32'h0,          0, 32'h4,          1, 32'h8C09_0000,  32'h8);
      vecs[11] = mk(0, 0, 0, 32'h0,          32'h0,          0, 32'h4,          1, 32'h8C09_0000,  32'h8);
      vecs[12] = mk(0, 0, 1, 32'h0109_5020,  32'h0,          1, 32'h8,          0, 32'h0,          32'hC);
      vecs[13] = mk(2, 1, 0, 32'h0,          32'h43,         0, 32'h8,          1, 32'h0109_5020,  32'hC);
      vecs[14] = mk(0, 2, 0, 32'h0,          32'h1000,       1, 32'h40,         0, 32'h0,          32'h44);
      vecs[15] = mk(0, 3, 0, 32'h0,          32'h2000,       1, 32'h40,         0, 32'h0,          32'h44);
      vecs[16] = mk(0, 0, 1, 32'hDEAD_BEEF,  32'h0,          1, 32'h40,         0, 32'h0,          32'h44);
      vecs[17] = mk(0, 0, 1, 32'h3C01_1234,  32'h0,          1, 32'h2000,       0, 32'h0,          32'h2004);
      vecs[18] = mk(1, 0, 0, 32'h0,          32'h0,          0, 32'h2000,       1, 32'h3C01_1234,  32'h2004);
      vecs[19] = mk(0, 2, 1, 32'h0000_AAAA,  32'hFFFF_FFFF,  1, 32'h2004,       0, 32'h0,          32'h2008);
      vecs[20] = mk(0, 0, 1, 32'h2402_0001,  32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0,          32'h0);
      vecs[21] = mk(0, 0, 0, 32'h0,          32'h0,          0, 32'hFFFF_FFFC,  1, 32'h2402_0001,  32'h0);
      vecs[22] = mk(0, 0, 0, 32'h0,          32'h0,          1, 32'h0,          0, 32'h0,          32'h4);

      drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset req",   {31'd0, bus.IMemReq},   32'd0);
      chk("reset addr",  bus.IMemAddr,           RESET_PC);
      chk("reset valid", {31'd0, bus.InstValid}, 32'd0);
      chk("reset inst",  bus.Inst,               32'h0);
      chk("reset pc4",   bus.PC4,                RESET_PC + 32'd4);

      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < N_VEC; i++) begin
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("row%0d req", i),   {31'd0, bus.IMemReq},   {31'd0, e.req});
         chk($sformatf("row%0d addr", i),  bus.IMemAddr,           e.addr);
         chk($sformatf("row%0d valid", i), {31'd0, bus.InstValid}, {31'd0, e.valid});
         chk($sformatf("row%0d inst", i),  bus.Inst,               e.inst);
         chk($sformatf("row%0d pc4", i),   bus.PC4,                e.pc4);
         @(posedge clk); #1;
      end

      // Reach REQ at a non-reset address, then reset asynchronously mid-request.
      drive(mk(0, 0, 1, 32'h1111_1111, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0));
      @(posedge clk); #1;
      drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0));
      @(posedge clk); #1;
      chk("pre-rst req",  {31'd0, bus.IMemReq}, 32'd1);
      chk("pre-rst addr", bus.IMemAddr,         32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst req",   {31'd0, bus.IMemReq},   32'd0);
      chk("async rst addr",  bus.IMemAddr,           RESET_PC);
      chk("async rst valid", {31'd0, bus.InstValid}, 32'd0);
      chk("async rst pc4",   bus.PC4,                RESET_PC + 32'd4);
      drive(mk(0, 0, 1, 32'h2222_2222, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0));
      @(posedge clk); #1;
      chk("rst late-ack req",   {31'd0, bus.IMemReq},   32'd0);
      chk("rst late-ack valid", {31'd0, bus.InstValid}, 32'd0);
      rst_n = 1'b1;
      drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0));
      @(negedge clk);
      chk("post-rst idle req", {31'd0, bus.IMemReq}, 32'd0);
      @(posedge clk); #1;
      chk("post-rst req",  {31'd0, bus.IMemReq}, 32'd1);
      chk("post-rst addr", bus.IMemAddr,         RESET_PC);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
